// File: rtl/decode_queue.sv
// RV32I decode stage: fetched instructions are decoded on accept and held in a
// circular queue whose head is offered to issue via valid/ready.
module decode_queue #(
    parameter  int DEPTH = 4,
    parameter  int PC_W  = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_pred,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic            out_use_imm,
    output logic            out_branch,
    output logic            out_ls,
    output logic            out_jalr,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc,
    output logic            out_pred,
    output logic [PTR_W:0]  count
);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,  OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8,  OP_AND  = 5'd9,  OP_LUI  = 5'd10, OP_AUIPC = 5'd11;
    localparam logic [4:0] OP_JAL  = 5'd12, OP_JALR = 5'd13, OP_BEQ  = 5'd14, OP_BNE  = 5'd15;
    localparam logic [4:0] OP_BLT  = 5'd16, OP_BGE  = 5'd17, OP_BLTU = 5'd18, OP_BGEU = 5'd19;
    localparam logic [4:0] OP_LB   = 5'd20, OP_LH   = 5'd21, OP_LW   = 5'd22, OP_LBU  = 5'd23;
    localparam logic [4:0] OP_LHU  = 5'd24, OP_SB   = 5'd25, OP_SH   = 5'd26, OP_SW   = 5'd27;

    typedef struct packed {
        logic [4:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            use_imm;
        logic            branch;
        logic            ls;
        logic            jalr;
        logic            illegal;
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             ent_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               full, enq, deq, ill;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opc    = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_sh = {27'b0, in_inst[24:20]};

    always_comb begin
        ent_d = '0;
        ill   = 1'b0;
        case (opc)
            7'b0110011: begin
                ent_d.rd  = in_inst[11:7];
                ent_d.rs1 = in_inst[19:15];
                ent_d.rs2 = in_inst[24:20];
                if (f7 == 7'b0100000 && f3 == 3'b000)      ent_d.op = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101) ent_d.op = OP_SRA;
                else if (f7 != 7'b0000000)                 ill = 1'b1;
                else begin
                    case (f3)
                        3'b000:  ent_d.op = OP_ADD;
                        3'b001:  ent_d.op = OP_SLL;
                        3'b010:  ent_d.op = OP_SLT;
                        3'b011:  ent_d.op = OP_SLTU;
                        3'b100:  ent_d.op = OP_XOR;
                        3'b101:  ent_d.op = OP_SRL;
                        3'b110:  ent_d.op = OP_OR;
                        default: ent_d.op = OP_AND;
                    endcase
                end
            end
            7'b0010011: begin
                ent_d.rd      = in_inst[11:7];
                ent_d.rs1     = in_inst[19:15];
                ent_d.use_imm = 1'b1;
                ent_d.imm     = imm_i;
                case (f3)
                    3'b000:  ent_d.op = OP_ADD;
                    3'b010:  ent_d.op = OP_SLT;
                    3'b011:  ent_d.op = OP_SLTU;
                    3'b100:  ent_d.op = OP_XOR;
                    3'b110:  ent_d.op = OP_OR;
                    3'b111:  ent_d.op = OP_AND;
                    3'b001: begin
                        ent_d.op  = OP_SLL;
                        ent_d.imm = imm_sh;
                        ill       = (f7 != 7'b0000000);
                    end
                    default: begin
                        // funct7 covers inst[25], so a set bit 25 lands here as illegal
                        ent_d.op  = (f7 == 7'b0100000) ? OP_SRA : OP_SRL;
                        ent_d.imm = imm_sh;
                        ill       = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                endcase
            end
            7'b0000011: begin
                ent_d.rd      = in_inst[11:7];
                ent_d.rs1     = in_inst[19:15];
                ent_d.imm     = imm_i;
                ent_d.use_imm = 1'b1;
                ent_d.ls      = 1'b1;
                case (f3)
                    3'b000:  ent_d.op = OP_LB;
                    3'b001:  ent_d.op = OP_LH;
                    3'b010:  ent_d.op = OP_LW;
                    3'b100:  ent_d.op = OP_LBU;
                    3'b101:  ent_d.op = OP_LHU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                ent_d.rs1     = in_inst[19:15];
                ent_d.rs2     = in_inst[24:20];
                ent_d.imm     = imm_s;
                ent_d.use_imm = 1'b1;
                ent_d.ls      = 1'b1;
                case (f3)
                    3'b000:  ent_d.op = OP_SB;
                    3'b001:  ent_d.op = OP_SH;
                    3'b010:  ent_d.op = OP_SW;
                    default: ill = 1'b1;
                endcase
            end
            7'b1100011: begin
                ent_d.rs1    = in_inst[19:15];
                ent_d.rs2    = in_inst[24:20];
                ent_d.imm    = imm_b;
                ent_d.branch = 1'b1;
                case (f3)
                    3'b000:  ent_d.op = OP_BEQ;
                    3'b001:  ent_d.op = OP_BNE;
                    3'b100:  ent_d.op = OP_BLT;
                    3'b101:  ent_d.op = OP_BGE;
                    3'b110:  ent_d.op = OP_BLTU;
                    3'b111:  ent_d.op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0110111, 7'b0010111: begin
                ent_d.op      = opc[5] ? OP_LUI : OP_AUIPC;
                ent_d.rd      = in_inst[11:7];
                ent_d.imm     = imm_u;
                ent_d.use_imm = 1'b1;
            end
            7'b1101111: begin
                ent_d.op      = OP_JAL;
                ent_d.rd      = in_inst[11:7];
                ent_d.imm     = imm_j;
                ent_d.use_imm = 1'b1;
            end
            7'b1100111: begin
                ent_d.op      = OP_JALR;
                ent_d.rd      = in_inst[11:7];
                ent_d.rs1     = in_inst[19:15];
                ent_d.imm     = imm_i;
                ent_d.use_imm = 1'b1;
                ent_d.jalr    = 1'b1;
                ill           = (f3 != 3'b000);
            end
            7'b0001111: begin
                ent_d.op      = OP_ADD;
                ent_d.use_imm = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal entries collapse to a bare ADD x0 so issue never acts on stray fields.
        if (ill) begin
            ent_d         = '0;
            ent_d.illegal = 1'b1;
        end
        ent_d.pc   = in_pc;
        ent_d.pred = in_pred;
    end

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign in_ready  = !full && rdy_in;
    assign out_valid = (count_q != '0);
    assign enq       = in_valid && in_ready && !flush_in;
    assign deq       = out_valid && out_ready && rdy_in && !flush_in;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                head_d  = head_q + PTR_W'(deq);
                tail_d  = tail_q + PTR_W'(enq);
                count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) mem_q[tail_q] <= ent_d;
    end

    assign out_op      = mem_q[head_q].op;
    assign out_rd      = mem_q[head_q].rd;
    assign out_rs1     = mem_q[head_q].rs1;
    assign out_rs2     = mem_q[head_q].rs2;
    assign out_imm     = mem_q[head_q].imm;
    assign out_use_imm = mem_q[head_q].use_imm;
    assign out_branch  = mem_q[head_q].branch;
    assign out_ls      = mem_q[head_q].ls;
    assign out_jalr    = mem_q[head_q].jalr;
    assign out_illegal = mem_q[head_q].illegal;
    assign out_pc      = mem_q[head_q].pc;
    assign out_pred    = mem_q[head_q].pred;
    assign count       = count_q;

endmodule
